// File: rtl/rca_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package rca_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int digits(int n, int k);
    return n / k;
  endfunction

  function automatic int cnt_w(int n, int k);
    return $clog2(n / k + 1);
  endfunction

endpackage

// File: rtl/rca_serial_addsub_digit.sv
// K-bit combinational ripple stage; also exposes the carry into its MSB.
module rca_digit #(
  parameter int K = 1
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] s,
  output logic         cout,
  output logic         c_msb_in
);

  always_comb begin
    logic cr;
    cr       = cin;
    s        = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (i == K - 1) c_msb_in = cr;
      s[i] = a[i] ^ b[i] ^ cr;
      cr   = (a[i] & b[i]) | (cr & (a[i] ^ b[i]));
    end
    cout = cr;
  end

endmodule

// File: rtl/rca_serial_addsub.sv
// Digit-serial N-bit add/sub, K bits per clock, start/done handshake.
// Optional saturation on signed overflow: define RCA_SERIAL_SAT_EN.
module rca_serial_addsub
  import rca_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         Ovf
);

  localparam int D  = digits(N, K);
  localparam int CW = cnt_w(N, K);

  generate
    if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad
      $error("rca_serial_addsub: illegal N/K");
    end
  endgenerate

  state_t         state;
  state_t         state_nx;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [N-1:0]   r_sh;
  logic           carry;
  logic [CW-1:0]  cnt;

  logic [K-1:0]   dsum;
  logic           dcout;
  logic           dcmsb;
  logic           last;
  logic [N-1:0]   r_nx;
  logic [N-1:0]   s_fin;
  logic           ovf_nx;

  rca_digit #(
    .K(K)
  ) u_digit (
    .a        (a_sh[K-1:0]),
    .b        (b_sh[K-1:0]),
    .cin      (carry),
    .s        (dsum),
    .cout     (dcout),
    .c_msb_in (dcmsb)
  );

  assign last   = (cnt == CW'(D - 1));
  assign ovf_nx = dcmsb ^ dcout;

  generate
    if (K == N) begin : g_one
      assign r_nx = dsum;
    end else begin : g_many
      assign r_nx = {dsum, r_sh[N-1:K]};
    end
  endgenerate

`ifdef RCA_SERIAL_SAT_EN
  logic a_sign;
  always_comb begin
    s_fin = r_nx;
    if (ovf_nx)
      s_fin = a_sign ? {1'b1, {(N-1){1'b0}}}
                     : {1'b0, {(N-1){1'b1}}};
  end
`else
  assign s_fin = r_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): if (start) state_nx = RUN;
      (state == RUN):  if (last)  state_nx = IDLE;
      default:         state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
`ifdef RCA_SERIAL_SAT_EN
      a_sign <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sh  <= A;
          b_sh  <= sub ? ~B : B;
          carry <= sub;
          cnt   <= '0;
`ifdef RCA_SERIAL_SAT_EN
          a_sign <= A[N-1];
`endif
        end
      end else begin
        a_sh  <= a_sh >> K;
        b_sh  <= b_sh >> K;
        r_sh  <= r_nx;
        carry <= dcout;
        cnt   <= cnt + 1'b1;
        if (last) begin
          S    <= s_fin;
          Cout <= dcout;
          Ovf  <= ovf_nx;
          done <= 1'b1;
        end
      end
    end
  end

endmodule
